// File: rtl/bus_arb_pkg.sv
// Shared definitions for the two-master bus arbiter.
//   arb_state_e : arbiter FSM states (IDLE, GNT0, GNT1)
//   M_INSTR     : index of the instruction master (m0)
//   M_DATA      : index of the data master (m1)
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_e;

  localparam logic M_INSTR = 1'b0;
  localparam logic M_DATA  = 1'b1;

endpackage

// File: rtl/bus_arb_timeout.sv
// Stall watchdog for the granted master's bus cycle.
// Counts cycles where the strobe is up and the slave has neither acked nor
// errored. When the count reaches TIMEOUT_CYCLES, hit_o is high for one
// cycle and the counter restarts.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   stb_i    : strobe of the granted master (before any forcing)
//   ack_i    : slave acknowledge
//   err_i    : slave error
//   clr_i    : grant is changing this cycle
//   hit_o    : stall limit reached (combinational from the count)
module bus_arb_timeout #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic stb_i,
  input  logic ack_i,
  input  logic err_i,
  input  logic clr_i,
  output logic hit_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign hit_o = (cnt_q == CW'(TIMEOUT_CYCLES));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || hit_o || ack_i || err_i) cnt_d = '0;
    else if (stb_i)                       cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master, one-slave bus arbiter with locked (non-preemptive) grants.
// m0 is the instruction port, m1 the data port. Ties from IDLE go to the
// master that did not win last time; after reset m0 wins the first tie.
// While a master is granted, the slave-side outputs are combinational copies
// of that master's inputs and the slave response is steered back to it only.
// Optional feature macro: BUS_ARBITER_TIMEOUT_EN -- adds a stall watchdog that
// pulses the granted master's err_o and suppresses s_stb_o for one cycle when
// the slave stalls for TIMEOUT_CYCLES cycles.
// Ports:
//   clk, rst                     : clock, asynchronous active-high reset
//   m{0,1}_cyc/stb/we/adr/dat/sel_i : master requests
//   m{0,1}_dat/ack/err_o         : responses to masters
//   s_cyc/stb/we/adr/dat/sel_o   : shared slave request
//   s_dat/ack/err_i              : slave response
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_cyc_i,
  input  logic              m0_stb_i,
  input  logic              m0_we_i,
  input  logic [XLEN-1:0]   m0_adr_i,
  input  logic [XLEN-1:0]   m0_dat_i,
  input  logic [XLEN/8-1:0] m0_sel_i,
  output logic [XLEN-1:0]   m0_dat_o,
  output logic              m0_ack_o,
  output logic              m0_err_o,
  input  logic              m1_cyc_i,
  input  logic              m1_stb_i,
  input  logic              m1_we_i,
  input  logic [XLEN-1:0]   m1_adr_i,
  input  logic [XLEN-1:0]   m1_dat_i,
  input  logic [XLEN/8-1:0] m1_sel_i,
  output logic [XLEN-1:0]   m1_dat_o,
  output logic              m1_ack_o,
  output logic              m1_err_o,
  output logic              s_cyc_o,
  output logic              s_stb_o,
  output logic              s_we_o,
  output logic [XLEN-1:0]   s_adr_o,
  output logic [XLEN-1:0]   s_dat_o,
  output logic [XLEN/8-1:0] s_sel_o,
  input  logic [XLEN-1:0]   s_dat_i,
  input  logic              s_ack_i,
  input  logic              s_err_i
);

  arb_state_e state_q, state_d;
  logic       last_grant_q, last_grant_d;
  logic       gnt_stb;
  logic       timeout_hit;

  // Next-state: grants are held while cyc stays high; on release the other
  // master is handed the bus directly if it is already waiting.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          if (last_grant_q == M_DATA) begin
            state_d = GNT0; last_grant_d = M_INSTR;
          end else begin
            state_d = GNT1; last_grant_d = M_DATA;
          end
        end else if (m0_cyc_i) begin
          state_d = GNT0; last_grant_d = M_INSTR;
        end else if (m1_cyc_i) begin
          state_d = GNT1; last_grant_d = M_DATA;
        end
      end
      GNT0: begin
        if (!m0_cyc_i) begin
          if (m1_cyc_i) begin
            state_d = GNT1; last_grant_d = M_DATA;
          end else begin
            state_d = IDLE;
          end
        end
      end
      GNT1: begin
        if (!m1_cyc_i) begin
          if (m0_cyc_i) begin
            state_d = GNT0; last_grant_d = M_INSTR;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= M_DATA;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign gnt_stb = ((state_q == GNT0) && m0_stb_i) ||
                   ((state_q == GNT1) && m1_stb_i);

`ifdef BUS_ARBITER_TIMEOUT_EN
  bus_arb_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk   (clk),
    .rst   (rst),
    .stb_i (gnt_stb),
    .ack_i (s_ack_i),
    .err_i (s_err_i),
    .clr_i (state_d != state_q),
    .hit_o (timeout_hit)
  );
`else
  // No watchdog in this build; the stall limit has no effect.
  assign timeout_hit = 1'b0 && (TIMEOUT_CYCLES == 0);
`endif

  // Output steering: everything is decoded from the registered state, so an
  // asynchronous reset drops the bus in the same cycle.
  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_sel_o  = '0;
    m0_dat_o = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_dat_o = '0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    case (state_q)
      GNT0: begin
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = gnt_stb && !timeout_hit;
        s_we_o   = m0_we_i;
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        s_sel_o  = m0_sel_i;
        m0_dat_o = s_dat_i;
        m0_ack_o = s_ack_i;
        m0_err_o = s_err_i || timeout_hit;
      end
      GNT1: begin
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = gnt_stb && !timeout_hit;
        s_we_o   = m1_we_i;
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        s_sel_o  = m1_sel_i;
        m1_dat_o = s_dat_i;
        m1_ack_o = s_ack_i;
        m1_err_o = s_err_i || timeout_hit;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed testbench for bus_arbiter. Inputs change 1 time unit after the
// rising edge; outputs are checked there too, well away from the next edge.
module tb_bus_arbiter;

  localparam int XLEN = 32;
  localparam int TO   = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            m0_cyc_i, m0_stb_i, m0_we_i;
  logic [XLEN-1:0] m0_adr_i, m0_dat_i;
  logic [3:0]      m0_sel_i;
  logic [XLEN-1:0] m0_dat_o;
  logic            m0_ack_o, m0_err_o;
  logic            m1_cyc_i, m1_stb_i, m1_we_i;
  logic [XLEN-1:0] m1_adr_i, m1_dat_i;
  logic [3:0]      m1_sel_i;
  logic [XLEN-1:0] m1_dat_o;
  logic            m1_ack_o, m1_err_o;
  logic            s_cyc_o, s_stb_o, s_we_o;
  logic [XLEN-1:0] s_adr_o, s_dat_o;
  logic [3:0]      s_sel_o;
  logic [XLEN-1:0] s_dat_i;
  logic            s_ack_i, s_err_i;

  int n_chk = 0;
  int n_err = 0;

  bus_arbiter #(.XLEN(XLEN), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  int errs;

  initial begin
    rst = 1'b0;
    {m0_cyc_i, m0_stb_i, m0_we_i, m1_cyc_i, m1_stb_i, m1_we_i} = '0;
    m0_adr_i = '0; m0_dat_i = '0; m0_sel_i = '0;
    m1_adr_i = '0; m1_dat_i = '0; m1_sel_i = '0;
    s_dat_i = '0; s_ack_i = 1'b0; s_err_i = 1'b0;
    #1 rst = 1'b1;
    #1;
    // Reset state: everything quiet, even with the slave driving ack.
    s_ack_i = 1'b1; s_dat_i = 32'h1234_5678;
    #1;
    chk("rst_s_cyc", {31'd0, s_cyc_o}, 32'd0);
    chk("rst_s_stb", {31'd0, s_stb_o}, 32'd0);
    chk("rst_m0_ack", {31'd0, m0_ack_o}, 32'd0);
    chk("rst_m1_dat", m1_dat_o, 32'd0);
    s_ack_i = 1'b0; s_dat_i = '0;
    tick();
    rst = 1'b0;

    // Single read by m0 at 0x100, ack after 2 cycles.
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'h100; m0_sel_i = 4'hF;
    chk("idle_s_cyc", {31'd0, s_cyc_o}, 32'd0);
    tick();
    chk("rd_s_cyc", {31'd0, s_cyc_o}, 32'd1);
    chk("rd_s_adr", s_adr_o, 32'h100);
    chk("rd_s_sel", {28'd0, s_sel_o}, 32'hF);
    tick();
    tick();
    s_ack_i = 1'b1; s_dat_i = 32'hDEAD_BEEF;
    #1;
    chk("rd_m0_dat", m0_dat_o, 32'hDEAD_BEEF);
    chk("rd_m0_ack", {31'd0, m0_ack_o}, 32'd1);
    chk("rd_m1_ack", {31'd0, m1_ack_o}, 32'd0);
    chk("rd_m1_dat", m1_dat_o, 32'd0);
    // Drop cyc in the ack cycle: ack still delivered.
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    #1;
    chk("drop_ack", {31'd0, m0_ack_o}, 32'd1);
    tick();
    s_ack_i = 1'b0; s_dat_i = '0;
    #1;
    chk("rel_s_cyc", {31'd0, s_cyc_o}, 32'd0);
    chk("rel_s_adr", s_adr_o, 32'd0);

    // Tie after reset: m0 first, then m1 with no IDLE gap.
    do_reset();
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'h200;
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_adr_i = 32'h300;
    tick();
    chk("tie1_adr", s_adr_o, 32'h200);
    s_ack_i = 1'b1;
    #1;
    chk("tie1_m0_ack", {31'd0, m0_ack_o}, 32'd1);
    chk("tie1_m1_ack", {31'd0, m1_ack_o}, 32'd0);
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    tick();
    s_ack_i = 1'b0;
    chk("handoff_cyc", {31'd0, s_cyc_o}, 32'd1);
    chk("handoff_adr", s_adr_o, 32'h300);
    m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    tick();

    // m0 alone, then a second tie goes to m1.
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    tick();
    chk("solo_adr", s_adr_o, 32'h200);
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    tick();
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
    tick();
    chk("tie2_adr", s_adr_o, 32'h300);
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    tick();

    // m1 4-beat write burst while m0 waits.
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_we_i = 1'b1;
    m1_adr_i = 32'h1000; m1_dat_i = 32'hA000;
    tick();
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'h400;
    for (int i = 0; i < 4; i++) begin
      m1_adr_i = 32'h1000 + 32'(4 * i);
      m1_dat_i = 32'hA000 + 32'(i);
      s_ack_i  = 1'b1;
      #1;
      chk("burst_adr", s_adr_o, 32'h1000 + 32'(4 * i));
      chk("burst_dat", s_dat_o, 32'hA000 + 32'(i));
      chk("burst_we", {31'd0, s_we_o}, 32'd1);
      chk("burst_m0_ack", {31'd0, m0_ack_o}, 32'd0);
      chk("burst_m1_ack", {31'd0, m1_ack_o}, 32'd1);
      if (i == 3) begin
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m1_we_i = 1'b0;
      end
      tick();
    end
    s_ack_i = 1'b0;
    #1;
    chk("after_burst_adr", s_adr_o, 32'h400);
    chk("after_burst_we", {31'd0, s_we_o}, 32'd0);
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    tick();

    // Reset pulsed while m1 holds the bus with stb high.
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_adr_i = 32'h500;
    tick();
    chk("pre_rst_cyc", {31'd0, s_cyc_o}, 32'd1);
    rst = 1'b1; s_ack_i = 1'b1;
    #1;
    chk("mid_rst_cyc", {31'd0, s_cyc_o}, 32'd0);
    chk("mid_rst_stb", {31'd0, s_stb_o}, 32'd0);
    chk("mid_rst_m1_ack", {31'd0, m1_ack_o}, 32'd0);
    chk("mid_rst_adr", s_adr_o, 32'd0);
    m1_cyc_i = 1'b0; m1_stb_i = 1'b0; s_ack_i = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    // Slave never acks.
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'h600;
    tick();
    errs = 0;
    for (int i = 0; i < 12; i++) begin
`ifdef BUS_ARBITER_TIMEOUT_EN
      chk("to_err", {31'd0, m0_err_o}, {31'd0, i == TO});
      chk("to_stb", {31'd0, s_stb_o}, {31'd0, i != TO});
`else
      chk("to_err", {31'd0, m0_err_o}, 32'd0);
      chk("to_stb", {31'd0, s_stb_o}, 32'd1);
`endif
      if (m0_err_o) errs++;
      tick();
    end
`ifdef BUS_ARBITER_TIMEOUT_EN
    chk("to_pulses", errs, 32'd1);
`else
    chk("to_pulses", errs, 32'd0);
`endif
    chk("to_held", {31'd0, s_cyc_o}, 32'd1);
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    tick();
    chk("to_rel", {31'd0, s_cyc_o}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
